// File: rtl/decode_stage.sv
// Registered decode stage with an ID/EX handshake register, load-use stall and flush.
// Optional write-back bypass into the held operands: define DECODE_WB_BYPASS_EN.

package decode_pkg;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       use_imm;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       illegal;
    } control_t;

endpackage

module decoder
    import decode_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     i_instr,
    output control_t        o_ctl,
    output logic [XLEN-1:0] o_imm
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];

    always_comb begin
        o_ctl   = '0;
        o_imm   = '0;
        unique case (w_opcode)
            7'b0000011: begin
                o_ctl.use_imm   = 1'b1;
                o_ctl.reg_write = 1'b1;
                o_ctl.mem_read  = 1'b1;
                o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
            end
            7'b0100011: begin
                o_ctl.use_imm   = 1'b1;
                o_ctl.mem_write = 1'b1;
                o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            end
            // Shift-right-immediate uses bit 30 to pick arithmetic vs logical.
            7'b0010011: begin
                o_ctl.use_imm   = 1'b1;
                o_ctl.reg_write = 1'b1;
                o_ctl.alu_op    = {(w_funct3 == 3'b101) & i_instr[30], w_funct3};
                o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
            end
            7'b0110011: begin
                o_ctl.reg_write = 1'b1;
                o_ctl.alu_op    = {i_instr[30], w_funct3};
            end
            7'b1100011: begin
                o_ctl.branch = 1'b1;
                o_ctl.alu_op = {1'b0, w_funct3};
                o_imm = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7],
                         i_instr[30:25], i_instr[11:8], 1'b0};
            end
            7'b1101111: begin
                o_ctl.jump      = 1'b1;
                o_ctl.reg_write = 1'b1;
                o_imm = {{(XLEN-21){i_instr[31]}}, i_instr[31], i_instr[19:12],
                         i_instr[20], i_instr[30:21], 1'b0};
            end
            7'b1100111: begin
                o_ctl.jump      = 1'b1;
                o_ctl.use_imm   = 1'b1;
                o_ctl.reg_write = 1'b1;
                o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
            end
            7'b0110111, 7'b0010111: begin
                o_ctl.use_imm   = 1'b1;
                o_ctl.reg_write = 1'b1;
                o_imm = {{(XLEN-32){i_instr[31]}}, i_instr[31:12], 12'b0};
            end
            default: o_ctl.illegal = 1'b1;
        endcase
    end

endmodule

module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [31:0]       in_instr,
    output logic [REG_AW-1:0] ra1,
    output logic [REG_AW-1:0] ra2,
    input  logic [XLEN-1:0]   rd1,
    input  logic [XLEN-1:0]   rd2,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [31:0]       out_instr,
    output control_t          out_ctl,
    output logic [XLEN-1:0]   out_imm,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic [REG_AW-1:0] out_dst,
    output logic [XLEN-1:0]   out_srca,
    output logic [XLEN-1:0]   out_srcb
);

    localparam logic [6:0] OP_LOAD = 7'b0000011;

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [31:0]       r_instr;
    control_t          r_ctl;
    logic [XLEN-1:0]   r_imm;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [REG_AW-1:0] r_dst;
    logic [XLEN-1:0]   r_srca;
    logic [XLEN-1:0]   r_srcb;

    logic [REG_AW-1:0] w_rs1;
    logic [REG_AW-1:0] w_rs2;
    logic [REG_AW-1:0] w_dst;
    control_t          w_ctl;
    logic [XLEN-1:0]   w_imm;
    logic              w_haz;
    logic              w_accept;
    logic [XLEN-1:0]   w_srca;
    logic [XLEN-1:0]   w_srcb;

    assign w_rs1 = in_instr[19:15];
    assign w_rs2 = in_instr[24:20];
    assign w_dst = in_instr[11:7];
    assign ra1   = w_rs1;
    assign ra2   = w_rs2;

    decoder #(.XLEN(XLEN)) u_decoder (
        .i_instr (in_instr),
        .o_ctl   (w_ctl),
        .o_imm   (w_imm)
    );

    // A held load whose destination feeds the offered instruction blocks it for one cycle.
    assign w_haz = r_valid & (r_instr[6:0] == OP_LOAD) & (r_dst != '0)
                 & ((r_dst == w_rs1) | (r_dst == w_rs2));

    assign in_ready = !flush & !w_haz & (!r_valid | out_ready);
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_srca = rd1;
        w_srcb = rd2;
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && (wb_dst != '0) && (wb_dst == w_rs1)) w_srca = wb_data;
        if (wb_en && (wb_dst != '0) && (wb_dst == w_rs2)) w_srcb = wb_data;
`endif
        if (w_rs1 == '0) w_srca = '0;
        if (w_rs2 == '0) w_srcb = '0;
    end

`ifndef DECODE_WB_BYPASS_EN
    logic w_unused_wb;
    assign w_unused_wb = ^{wb_en, wb_dst, wb_data};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= '0;
            r_ctl   <= '0;
            r_imm   <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_dst   <= '0;
            r_srca  <= '0;
            r_srcb  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_pc    <= in_pc;
            r_instr <= in_instr;
            r_ctl   <= w_ctl;
            r_imm   <= w_imm;
            r_rs1   <= w_rs1;
            r_rs2   <= w_rs2;
            r_dst   <= w_dst;
            r_srca  <= w_srca;
            r_srcb  <= w_srcb;
        end else begin
            if (r_valid && out_ready) r_valid <= 1'b0;
`ifdef DECODE_WB_BYPASS_EN
            // wb_dst != 0 also keeps x0 operands pinned at zero.
            if (r_valid && wb_en && (wb_dst != '0) && (wb_dst == r_rs1)) r_srca <= wb_data;
            if (r_valid && wb_en && (wb_dst != '0) && (wb_dst == r_rs2)) r_srcb <= wb_data;
`endif
        end
    end

    assign out_valid = r_valid;
    assign out_pc    = r_pc;
    assign out_instr = r_instr;
    assign out_ctl   = r_ctl;
    assign out_imm   = r_imm;
    assign out_rs1   = r_rs1;
    assign out_rs2   = r_rs2;
    assign out_dst   = r_dst;
    assign out_srca  = r_srca;
    assign out_srcb  = r_srcb;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, streaming, load-use bubble, hold, flush, bypass.
// Expectations follow DECODE_WB_BYPASS_EN when it is defined for the build.

module tb_decode_stage;
    import decode_pkg::*;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    localparam logic [31:0] ADDI_X1_X0_5 = 32'h0050_0093;
    localparam logic [31:0] ADDI_X2_X0_7 = 32'h0070_0113;
    localparam logic [31:0] LW_X5_0_X1   = 32'h0000_A283;
    localparam logic [31:0] ADD_X6_X5_X5 = 32'h0052_8333;
    localparam logic [31:0] LW_X0_0_X1   = 32'h0000_A003;
    localparam logic [31:0] ADDI_X7_X3_1 = 32'h0011_8393;
    localparam logic [31:0] ADD_X4_X3_X3 = 32'h0031_8233;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [31:0]       in_instr;
    logic [REG_AW-1:0] ra1;
    logic [REG_AW-1:0] ra2;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic              wb_en;
    logic [REG_AW-1:0] wb_dst;
    logic [XLEN-1:0]   wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [31:0]       out_instr;
    control_t          out_ctl;
    logic [XLEN-1:0]   out_imm;
    logic [REG_AW-1:0] out_rs1;
    logic [REG_AW-1:0] out_rs2;
    logic [REG_AW-1:0] out_dst;
    logic [XLEN-1:0]   out_srca;
    logic [XLEN-1:0]   out_srcb;

    logic [XLEN-1:0] regs [32];
    int nCompared;
    int nMismatched;
    logic [XLEN-1:0] expHeldA;
    logic [XLEN-1:0] expBypass;

    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];

    decode_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .ra1       (ra1),
        .ra2       (ra2),
        .rd1       (rd1),
        .rd2       (rd2),
        .wb_en     (wb_en),
        .wb_dst    (wb_dst),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ctl   (out_ctl),
        .out_imm   (out_imm),
        .out_rs1   (out_rs1),
        .out_rs2   (out_rs2),
        .out_dst   (out_dst),
        .out_srca  (out_srca),
        .out_srcb  (out_srcb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just past the next rising edge so new inputs land mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [XLEN-1:0] pc,
                                 input logic [31:0] instr);
        in_valid = valid;
        in_pc    = pc;
        in_instr = instr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                               input logic [XLEN-1:0] expected);
        nCompared++;
        assert (observed === expected)
        else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? '0 : 64'h1000 + 64'(i);
`ifdef DECODE_WB_BYPASS_EN
        expHeldA  = 64'hDEAD;
        expBypass = 64'h11;
`else
        expHeldA  = 64'h1003;
        expBypass = 64'h0;
`endif
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        wb_en = 1'b0; wb_dst = '0; wb_data = '0;
        in_valid = 1'b1; in_pc = 64'h80; in_instr = ADDI_X1_X0_5;

        // Reset with an instruction on offer
        step();
        step();
        checkOutput("reset_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_srca", out_srca, 64'd0);
        checkOutput("reset_pc", out_pc, 64'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 64'h0, 32'h0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);

        // Back-to-back stream
        step();
        applyStimulus(1'b1, 64'h100, ADDI_X1_X0_5);
        checkOutput("s_in_ready0", 64'(in_ready), 64'd1);
        step();
        applyStimulus(1'b1, 64'h104, ADDI_X2_X0_7);
        checkOutput("s_valid0", 64'(out_valid), 64'd1);
        checkOutput("s_pc0", out_pc, 64'h100);
        checkOutput("s_imm0", out_imm, 64'd5);
        checkOutput("s_dst0", 64'(out_dst), 64'd1);
        checkOutput("s_srca0", out_srca, 64'd0);
        checkOutput("s_regwr0", 64'(out_ctl.reg_write), 64'd1);
        checkOutput("s_in_ready1", 64'(in_ready), 64'd1);
        step();
        applyStimulus(1'b0, 64'h0, 32'h0);
        checkOutput("s_valid1", 64'(out_valid), 64'd1);
        checkOutput("s_pc1", out_pc, 64'h104);
        checkOutput("s_imm1", out_imm, 64'd7);
        checkOutput("s_dst1", 64'(out_dst), 64'd2);
        step();
        checkOutput("s_drain", 64'(out_valid), 64'd0);

        // Load-use: exactly one bubble
        applyStimulus(1'b1, 64'h200, LW_X5_0_X1);
        step();
        applyStimulus(1'b1, 64'h204, ADD_X6_X5_X5);
        checkOutput("lu_instr", 64'(out_instr), 64'(LW_X5_0_X1));
        checkOutput("lu_memrd", 64'(out_ctl.mem_read), 64'd1);
        checkOutput("lu_srca", out_srca, 64'h1001);
        checkOutput("lu_stall", 64'(in_ready), 64'd0);
        step();
        checkOutput("lu_bubble", 64'(out_valid), 64'd0);
        checkOutput("lu_in_ready", 64'(in_ready), 64'd1);
        step();
        applyStimulus(1'b1, 64'h208, LW_X0_0_X1);
        checkOutput("lu_add_valid", 64'(out_valid), 64'd1);
        checkOutput("lu_add_pc", out_pc, 64'h204);
        checkOutput("lu_add_srca", out_srca, 64'h1005);
        checkOutput("lu_add_srcb", out_srcb, 64'h1005);
        step();
        applyStimulus(1'b1, 64'h20C, ADD_X6_X5_X5);
        checkOutput("lw0_pc", out_pc, 64'h208);
        checkOutput("lw0_no_stall", 64'(in_ready), 64'd1);
        step();
        applyStimulus(1'b0, 64'h0, 32'h0);
        checkOutput("lw0_next_pc", out_pc, 64'h20C);
        checkOutput("lw0_next_valid", 64'(out_valid), 64'd1);
        step();

        // Hold for three cycles, then write-back into the held entry
        out_ready = 1'b0;
        applyStimulus(1'b1, 64'h300, ADDI_X7_X3_1);
        step();
        applyStimulus(1'b1, 64'h304, ADDI_X1_X0_5);
        checkOutput("h_srca0", out_srca, 64'h1003);
        checkOutput("h_in_ready0", 64'(in_ready), 64'd0);
        step();
        step();
        step();
        checkOutput("h_valid", 64'(out_valid), 64'd1);
        checkOutput("h_pc", out_pc, 64'h300);
        checkOutput("h_imm", out_imm, 64'd1);
        checkOutput("h_rs1", 64'(out_rs1), 64'd3);
        checkOutput("h_srcb", out_srcb, 64'h1001);
        checkOutput("h_in_ready", 64'(in_ready), 64'd0);
        wb_en = 1'b1; wb_dst = 5'd3; wb_data = 64'hDEAD;
        step();
        wb_en = 1'b0;
        checkOutput("h_wb_srca", out_srca, expHeldA);
        checkOutput("h_wb_srcb", out_srcb, 64'h1001);
        checkOutput("h_wb_pc", out_pc, 64'h300);

        // Flush kills the entry and refuses the offered instruction
        out_ready = 1'b1;
        flush     = 1'b1;
        #1;
        checkOutput("f_in_ready", 64'(in_ready), 64'd0);
        step();
        flush = 1'b0;
        #1;
        checkOutput("f_valid", 64'(out_valid), 64'd0);
        checkOutput("f_in_ready_after", 64'(in_ready), 64'd1);
        step();
        applyStimulus(1'b0, 64'h0, 32'h0);
        checkOutput("f_retry_valid", 64'(out_valid), 64'd1);
        checkOutput("f_retry_pc", out_pc, 64'h304);
        step();

        // Capture-time bypass against a zero regfile value
        regs[3] = '0;
        wb_en = 1'b1; wb_dst = 5'd3; wb_data = 64'h11;
        applyStimulus(1'b1, 64'h400, ADD_X4_X3_X3);
        step();
        wb_en = 1'b0;
        applyStimulus(1'b0, 64'h0, 32'h0);
        checkOutput("b_pc", out_pc, 64'h400);
        checkOutput("b_srca", out_srca, expBypass);
        checkOutput("b_srcb", out_srcb, expBypass);
        checkOutput("b_dst", 64'(out_dst), 64'd4);
        step();
        checkOutput("b_drain", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
